// File: rtl/branch_predict_profiler_pkg.sv
// rtl/branch_predict_profiler_pkg.sv - shared types for the branch prediction profiler
package branch_predict_profiler_pkg;

    localparam int NUM_CNTS  = 8;
    // Wide enough for a per-cycle increment of 0..4 ports
    localparam int INC_WIDTH = 3;

    typedef enum logic [2:0] {
        CNT_BRANCH         = 3'd0,
        CNT_PRED_TAKEN     = 3'd1,
        CNT_PRED_NOT_TAKEN = 3'd2,
        CNT_DIR_CORRECT    = 3'd3,
        CNT_TARGET_UNPRED  = 3'd4,
        CNT_MISS           = 3'd5,
        CNT_MISS_TAKEN     = 3'd6,
        CNT_MISS_NOT_TAKEN = 3'd7
    } cnt_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } prof_state_e;

    typedef logic [31:0] pc_t;

endpackage

// File: rtl/branch_predict_profiler_sat_counter.sv
// rtl/branch_predict_profiler_sat_counter.sv - saturating statistic counter (profiler_sat_counter)
module profiler_sat_counter
    import branch_predict_profiler_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [INC_WIDTH-1:0] inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 sat_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH+1:0] sum;
    logic                 clip;

    // Add with two guard bits; any carry into them means the increment was clipped
    always_comb begin
        sum   = {2'b00, cnt_q} + {{(CNT_WIDTH-1){1'b0}}, inc_i};
        clip  = |sum[CNT_WIDTH+1:CNT_WIDTH];
        cnt_d = cnt_q;
        sat_o = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (clip) begin
                cnt_d = '1;
                sat_o = 1'b1;
            end else begin
                cnt_d = sum[CNT_WIDTH-1:0];
            end
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predict_profiler.sv
// rtl/branch_predict_profiler.sv - windowed branch prediction statistics; BRANCH_PROFILER_SNAPSHOT_EN adds a frozen shadow bank
module branch_predict_profiler
    import branch_predict_profiler_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int CNT_WIDTH  = 32,
    parameter int WINDOW_LEN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 clear,
    input  logic [NUM_PORTS-1:0] valid,
    input  logic [NUM_PORTS-1:0] isBranchTaken,
    input  pc_t  [NUM_PORTS-1:0] actualNextPc,
    input  logic [NUM_PORTS-1:0] predTaken,
    input  logic [NUM_PORTS-1:0] predNextPcValid,
    input  pc_t  [NUM_PORTS-1:0] predNextPc,
    input  logic [2:0]           rd_sel,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic [1:0]           state,
    output logic                 window_done,
    output logic                 overflow
);

    localparam logic [31:0] WIN_LIMIT = 32'(WINDOW_LEN);

    prof_state_e          state_q, state_d;
    logic [31:0]          win_q, win_d;
    logic                 overflow_q, overflow_d;
    logic                 window_done_q, window_done_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

    logic                 restart;
    logic                 counting;
    logic                 cnt_clr;

    logic [NUM_PORTS-1:0] miss_t, miss_nt;
    logic [INC_WIDTH-1:0] inc [NUM_CNTS];
    logic [CNT_WIDTH-1:0] cnt [NUM_CNTS];
    logic [NUM_CNTS-1:0]  sat;

    // Window FSM: a lone start (re)opens a window, stop or budget exhaustion freezes it
    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        restart  = 1'b0;
        counting = 1'b0;
        case (state_q)
            ST_IDLE, ST_FROZEN: begin
                if (start && !stop) begin
                    state_d = ST_RUN;
                    restart = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d  = ST_FROZEN;
                    counting = 1'b1;
                    win_d    = win_q + 32'd1;
                end else if (start) begin
                    restart = 1'b1;
                end else begin
                    counting = 1'b1;
                    win_d    = win_q + 32'd1;
                    if ((WINDOW_LEN != 0) && (win_d == WIN_LIMIT)) state_d = ST_FROZEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (restart) win_d = '0;
        window_done_d = (state_q == ST_RUN) && (state_d == ST_FROZEN);
    end

    assign cnt_clr    = clear | restart;
    assign overflow_d = cnt_clr ? 1'b0 : (overflow_q | (|sat));

    // Per-port target mispredictions, split by predicted direction
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            miss_t[p]  = predTaken[p] & predNextPcValid[p] & (predNextPc[p] != actualNextPc[p]);
            miss_nt[p] = !predTaken[p] & (predNextPc[p] != actualNextPc[p]);
        end
    end

    // Popcount of qualifying valid ports for each statistic
    always_comb begin
        for (int k = 0; k < NUM_CNTS; k++) inc[k] = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (valid[p]) begin
                inc[CNT_BRANCH] = inc[CNT_BRANCH] + 3'd1;
                if (predTaken[p]) inc[CNT_PRED_TAKEN]     = inc[CNT_PRED_TAKEN] + 3'd1;
                else              inc[CNT_PRED_NOT_TAKEN] = inc[CNT_PRED_NOT_TAKEN] + 3'd1;
                if (predTaken[p] == isBranchTaken[p])
                    inc[CNT_DIR_CORRECT] = inc[CNT_DIR_CORRECT] + 3'd1;
                if (!predNextPcValid[p])
                    inc[CNT_TARGET_UNPRED] = inc[CNT_TARGET_UNPRED] + 3'd1;
                if (miss_t[p])  inc[CNT_MISS_TAKEN]     = inc[CNT_MISS_TAKEN] + 3'd1;
                if (miss_nt[p]) inc[CNT_MISS_NOT_TAKEN] = inc[CNT_MISS_NOT_TAKEN] + 3'd1;
                if (miss_t[p] || miss_nt[p]) inc[CNT_MISS] = inc[CNT_MISS] + 3'd1;
            end
        end
    end

    for (genvar k = 0; k < NUM_CNTS; k++) begin : g_cnt
        profiler_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (cnt_clr),
            .en_i  (counting),
            .inc_i (inc[k]),
            .cnt_o (cnt[k]),
            .sat_o (sat[k])
        );
    end

`ifdef BRANCH_PROFILER_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shadow_q [NUM_CNTS];

    // First FROZEN cycle: live counters hold the final window totals, copy them
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CNTS; k++) shadow_q[k] <= '0;
        end else if (window_done_q) begin
            for (int k = 0; k < NUM_CNTS; k++) shadow_q[k] <= cnt[k];
        end
    end

    assign rd_data_d = shadow_q[rd_sel];
`else
    assign rd_data_d = cnt[rd_sel];
`endif

    // Control and read-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            win_q         <= '0;
            overflow_q    <= 1'b0;
            window_done_q <= 1'b0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            win_q         <= win_d;
            overflow_q    <= overflow_d;
            window_done_q <= window_done_d;
            rd_data_q     <= rd_data_d;
        end
    end

    assign state       = state_q;
    assign window_done = window_done_q;
    assign overflow    = overflow_q;
    assign rd_data     = rd_data_q;

endmodule
